// File: rtl/spi_dev_pkg.sv
// Shared SPI device definitions: FSM state encoding and the idle fill byte.
package spi_dev_pkg;

  typedef logic [1:0] spi_dev_state_t;

  localparam spi_dev_state_t ST_IDLE = 2'd0;
  localparam spi_dev_state_t ST_WAIT = 2'd1;
  localparam spi_dev_state_t ST_SEND = 2'd2;
  localparam spi_dev_state_t ST_DONE = 2'd3;

  localparam logic [7:0] SPI_DEV_FILL_BYTE = 8'h00;

endpackage

// File: rtl/spi_dev_sresp.sv
// SPI device single-response block: a matching command byte fetches a word from
// the fabric and streams it MSB byte first. Optional SPI_DEV_SRESP_REPEAT_EN repeats it.
module spi_dev_sresp
  import spi_dev_pkg::*;
#(
  parameter logic [7:0]  CMD_BYTE = 8'h00,
  parameter int unsigned RSP_LEN  = 4,
  parameter int unsigned DL       = (8 * RSP_LEN) - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    pw_wdata,
  input  logic          pw_wcmd,
  input  logic          pw_wstb,
  input  logic          pw_end,
  output logic [7:0]    pw_rdata,
  output logic          pw_rvalid,
  input  logic          pw_rstb,
  output logic          resp_req,
  input  logic [DL:0]   resp_data,
  input  logic          resp_ack
);

  localparam int unsigned CW = $clog2(RSP_LEN + 1);

  spi_dev_state_t state_q, state_d;
  logic [DL:0]    sh_q, sh_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           req_d;
  logic [7:0]     rdata_d;
  logic           rvalid_d;
  logic           cmd_match_c;
  logic           cmd_other_c;
  logic           last_byte_c;
`ifdef SPI_DEV_SRESP_REPEAT_EN
  logic [DL:0]    copy_q, copy_d;
`endif

  assign cmd_match_c = pw_wstb & pw_wcmd & (pw_wdata == CMD_BYTE);
  assign cmd_other_c = pw_wstb & pw_wcmd & (pw_wdata != CMD_BYTE);
  assign last_byte_c = (cnt_q == CW'(RSP_LEN - 1));

  // Next-state and next-output logic; pw_end outranks everything else.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    req_d   = 1'b0;
`ifdef SPI_DEV_SRESP_REPEAT_EN
    copy_d  = copy_q;
`endif
    if (pw_end) begin
      state_d = ST_IDLE;
    end else if (cmd_match_c) begin
      state_d = ST_WAIT;
      req_d   = 1'b1;
    end else if (cmd_other_c) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (resp_ack) begin
            sh_d    = resp_data;
            cnt_d   = '0;
            state_d = ST_SEND;
`ifdef SPI_DEV_SRESP_REPEAT_EN
            copy_d  = resp_data;
`endif
          end
        end
        ST_SEND: begin
          if (pw_rstb) begin
            sh_d  = sh_q << 8;
            cnt_d = cnt_q + CW'(1);
            if (last_byte_c) begin
`ifdef SPI_DEV_SRESP_REPEAT_EN
              sh_d  = copy_q;
              cnt_d = '0;
`else
              state_d = ST_DONE;
`endif
            end
          end
        end
        default: ;
      endcase
    end
    rvalid_d = (state_d == ST_SEND);
    rdata_d  = rvalid_d ? sh_d[DL -: 8] : SPI_DEV_FILL_BYTE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      pw_rdata  <= SPI_DEV_FILL_BYTE;
      pw_rvalid <= 1'b0;
      resp_req  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      pw_rdata  <= rdata_d;
      pw_rvalid <= rvalid_d;
      resp_req  <= req_d;
    end
  end

`ifdef SPI_DEV_SRESP_REPEAT_EN
  // Copy of the captured word used to reload the shifter on wrap-around.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) copy_q <= '0;
    else        copy_q <= copy_d;
  end
`endif

endmodule

// File: tb/tb_spi_dev_sresp.sv
// Self-checking bench for spi_dev_sresp: directed vector table, reset and
// repeat/done sequences, then random traffic against a byte-queue model.
module tb_spi_dev_sresp;

`ifdef SPI_DEV_SRESP_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  wd;
  logic        wc, ws, en, rs, ak;
  logic [31:0] d;
  logic [7:0]  rdata;
  logic        rvalid, req;

  logic [7:0]  b_wd;
  logic        b_wc, b_ws, b_en, b_rs, b_ak;
  logic [15:0] b_d;
  logic [7:0]  b_rdata;
  logic        b_rvalid, b_req;

  spi_dev_sresp #(.CMD_BYTE(8'hA5), .RSP_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .pw_wdata(wd), .pw_wcmd(wc), .pw_wstb(ws),
    .pw_end(en), .pw_rdata(rdata), .pw_rvalid(rvalid), .pw_rstb(rs),
    .resp_req(req), .resp_data(d), .resp_ack(ak));

  spi_dev_sresp #(.CMD_BYTE(8'hA5), .RSP_LEN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .pw_wdata(b_wd), .pw_wcmd(b_wc), .pw_wstb(b_ws),
    .pw_end(b_en), .pw_rdata(b_rdata), .pw_rvalid(b_rvalid), .pw_rstb(b_rs),
    .resp_req(b_req), .resp_data(b_d), .resp_ack(b_ak));

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 awaiting ack, 2 sending, 3 finished.
  int          m_ph;
  logic [7:0]  m_q[$];
  logic [31:0] m_word;
  logic        m_req;

  function automatic void m_load(input logic [31:0] w);
    m_q.delete();
    for (int i = 3; i >= 0; i--) m_q.push_back(w[8*i +: 8]);
  endfunction

  function automatic void m_reset();
    m_ph = 0; m_q.delete(); m_req = 1'b0; m_word = '0;
  endfunction

  function automatic void m_step();
    m_req = 1'b0;
    if (en) begin
      m_ph = 0; m_q.delete();
    end else if (ws && wc) begin
      m_q.delete();
      if (wd == 8'hA5) begin m_ph = 1; m_req = 1'b1; end
      else m_ph = 0;
    end else if (m_ph == 1 && ak) begin
      m_word = d; m_load(d); m_ph = 2;
    end else if (m_ph == 2 && rs) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        if (REP) m_load(m_word);
        else m_ph = 3;
      end
    end
  endfunction

  typedef struct {
    logic [7:0]  wd;
    logic        wc, ws, en, rs, ak;
    logic [31:0] d;
    logic [7:0]  er;
    logic        ev, eq;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic [7:0] w, input logic c, input logic s,
                              input logic e, input logic r, input logic a,
                              input logic [31:0] dd, input logic [7:0] er,
                              input logic ev, input logic eq);
    vec_t v;
    v.wd = w; v.wc = c; v.ws = s; v.en = e; v.rs = r; v.ak = a; v.d = dd;
    v.er = er; v.ev = ev; v.eq = eq;
    tv.push_back(v);
  endfunction

  task automatic idle_inputs();
    wd = 8'h00; wc = 0; ws = 0; en = 0; rs = 0; ak = 0; d = '0;
  endtask

  task automatic b_idle();
    b_wd = 8'h00; b_wc = 0; b_ws = 0; b_en = 0; b_rs = 0; b_ak = 0; b_d = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] rep_exp[5];

  initial begin
    idle_inputs(); b_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rdata", 32'(rdata), 32'h00);
    chk("reset rvalid", 32'(rvalid), 32'h0);
    chk("reset req", 32'(req), 32'h0);
    rst_n = 1'b1;

    //   wd     c  s  e  r  a  data          rdata  v  req
    add(8'hA5, 1, 1, 0, 0, 0, 32'h0,        8'h00, 0, 1);
    add(8'h00, 0, 0, 0, 0, 0, 32'h0,        8'h00, 0, 0);
    add(8'h00, 0, 0, 0, 1, 0, 32'h0,        8'h00, 0, 0);
    add(8'h00, 0, 0, 0, 1, 0, 32'h0,        8'h00, 0, 0);
    add(8'h00, 0, 0, 0, 0, 1, 32'h11223344, 8'h11, 1, 0);
    add(8'h00, 0, 0, 0, 0, 0, 32'h0,        8'h11, 1, 0);
    add(8'h00, 0, 0, 0, 1, 0, 32'h0,        8'h22, 1, 0);
    add(8'h00, 0, 0, 0, 1, 0, 32'h0,        8'h33, 1, 0);
    add(8'h00, 0, 0, 0, 1, 0, 32'h0,        8'h44, 1, 0);
    add(8'h00, 0, 0, 0, 1, 0, 32'h0,        REP ? 8'h11 : 8'h00, REP, 0);
    add(8'h00, 0, 0, 0, 1, 0, 32'h0,        REP ? 8'h22 : 8'h00, REP, 0);
    add(8'h00, 0, 0, 0, 0, 1, 32'h99999999, REP ? 8'h22 : 8'h00, REP, 0);
    add(8'h5A, 1, 1, 0, 0, 0, 32'h0,        8'h00, 0, 0);
    add(8'h00, 0, 0, 0, 0, 0, 32'h0,        8'h00, 0, 0);
    add(8'h00, 0, 0, 0, 0, 1, 32'hDEADBEEF, 8'h00, 0, 0);
    add(8'hA5, 1, 1, 0, 0, 0, 32'h0,        8'h00, 0, 1);
    add(8'h00, 0, 0, 0, 1, 0, 32'h0,        8'h00, 0, 0);
    add(8'h00, 0, 0, 0, 0, 1, 32'hDEADBEEF, 8'hDE, 1, 0);
    add(8'h00, 0, 0, 0, 1, 0, 32'h0,        8'hAD, 1, 0);
    add(8'h00, 0, 0, 0, 1, 0, 32'h0,        8'hBE, 1, 0);
    add(8'h00, 0, 0, 1, 0, 0, 32'h0,        8'h00, 0, 0);
    add(8'hA5, 1, 1, 0, 0, 0, 32'h0,        8'h00, 0, 1);
    add(8'h00, 0, 0, 0, 0, 1, 32'h01020304, 8'h01, 1, 0);
    add(8'h00, 0, 0, 0, 1, 0, 32'h0,        8'h02, 1, 0);
    add(8'h00, 0, 0, 1, 1, 0, 32'h0,        8'h00, 0, 0);
    add(8'hA5, 1, 1, 1, 0, 0, 32'h0,        8'h00, 0, 0);
    add(8'hA5, 1, 1, 0, 0, 0, 32'h0,        8'h00, 0, 1);
    add(8'h00, 0, 0, 1, 0, 1, 32'h11223344, 8'h00, 0, 0);
    add(8'h00, 0, 0, 0, 0, 0, 32'h0,        8'h00, 0, 0);
    add(8'hA5, 1, 1, 0, 0, 0, 32'h0,        8'h00, 0, 1);
    add(8'h00, 0, 0, 0, 0, 1, 32'h55667788, 8'h55, 1, 0);
    add(8'hA5, 1, 1, 0, 0, 0, 32'h0,        8'h00, 0, 1);
    add(8'h00, 0, 0, 0, 0, 1, 32'h0A0B0C0D, 8'h0A, 1, 0);
    add(8'h00, 0, 0, 0, 1, 0, 32'h0,        8'h0B, 1, 0);

    foreach (tv[i]) begin
      wd = tv[i].wd; wc = tv[i].wc; ws = tv[i].ws; en = tv[i].en;
      rs = tv[i].rs; ak = tv[i].ak; d = tv[i].d;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d rdata", i), 32'(rdata), 32'(tv[i].er));
      chk($sformatf("vec%0d rvalid", i), 32'(rvalid), 32'(tv[i].ev));
      chk($sformatf("vec%0d req", i), 32'(req), 32'(tv[i].eq));
    end
    idle_inputs();

    // Asynchronous reset in the middle of a response.
    #2 rst_n = 1'b0;
    #1;
    chk("async rst rdata", 32'(rdata), 32'h00);
    chk("async rst rvalid", 32'(rvalid), 32'h0);
    chk("async rst req", 32'(req), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post rst req%0d", i), 32'(req), 32'h0);
      chk($sformatf("post rst rvalid%0d", i), 32'(rvalid), 32'h0);
    end

    // Two-byte instance: wrap-around when repeating, else finished after two.
    rep_exp[0] = 8'hCA; rep_exp[1] = 8'hFE;
    rep_exp[2] = REP ? 8'hCA : 8'h00;
    rep_exp[3] = REP ? 8'hFE : 8'h00;
    rep_exp[4] = REP ? 8'hCA : 8'h00;
    b_wd = 8'hA5; b_wc = 1; b_ws = 1;
    @(posedge clk); @(negedge clk);
    chk("two-byte req", 32'(b_req), 32'h1);
    b_idle(); b_ak = 1; b_d = 16'hCAFE;
    @(posedge clk); @(negedge clk);
    b_idle();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("two-byte rdata%0d", i), 32'(b_rdata), 32'(rep_exp[i]));
      chk($sformatf("two-byte rvalid%0d", i), 32'(b_rvalid), 32'(REP || i < 2));
      b_rs = 1;
      @(posedge clk); @(negedge clk);
    end
    b_idle();
    chk("two-byte after5 rdata", 32'(b_rdata), REP ? 32'hFE : 32'h00);

    // Random traffic against the byte-queue model.
    do_reset();
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(99) < 4);
      ws = ($urandom_range(99) < 20);
      wc = ws & $urandom_range(1);
      case ($urandom_range(2))
        0: wd = 8'hA5;
        1: wd = 8'h5A;
        default: wd = 8'($urandom);
      endcase
      ak = ($urandom_range(99) < 25);
      rs = ($urandom_range(99) < 40);
      d  = $urandom;
      @(posedge clk);
      m_step();
      @(negedge clk);
      chk($sformatf("rand%0d rdata", i), 32'(rdata),
          (m_ph == 2) ? 32'(m_q[0]) : 32'h0);
      chk($sformatf("rand%0d rvalid", i), 32'(rvalid), 32'(m_ph == 2));
      chk($sformatf("rand%0d req", i), 32'(req), 32'(m_req));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
